ppi_bus_control: RTL and testbench

//  - Upstream bus-interface/control stage of the 8255-style PPI: turns async CS_n/RD_n/WR_n/A/D bus cycles into
//    clk-synchronous strobes for the INOUT mode/port block (A, READ, WRITE, data).
//  - Holds the control word register and decodes port-C bit set/reset (BSR) commands.
//  - Drives the read-back data onto the CPU data bus.

---
 rtl/ppi_bus_control.sv | 188 ++++++++++++++++++
 tb/tb_ppi_bus_control.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_bus_control.sv
// Bus-interface/control stage of an 8255-style PPI: synchronizes CPU bus cycles into clk-domain strobes.
// Define PPI_CTRL_READBACK_EN to let CPU reads of the control address return the control word.
module ppi_bus_control #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CTRL_RESET  = 8'h9B
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic [1:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] rd_data,
    output logic [1:0] addr_out,
    output logic       READ,
    output logic       WRITE,
    output logic [7:0] wr_data,
    output logic [7:0] ctrl_word,
    output logic       mode_set,
    output logic       bsr_we,
    output logic [2:0] bsr_bit,
    output logic       bsr_val,
    output logic       bus_conflict
);
    typedef enum logic [1:0] {IDLE = 2'd0, WR_ACT = 2'd1, RD_ACT = 2'd2, ERR = 2'd3} state_e;
    localparam logic [1:0] ADDR_CTRL = 2'b11;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, rd_sync_q, rd_sync_d, wr_sync_q, wr_sync_d;
    logic                   cs, rd, wr, commit;
    logic [1:0]             cap_addr_q, cap_addr_d, addr_q, addr_d;
    logic [7:0]             cap_data_q, cap_data_d, wr_data_q, wr_data_d;
    logic [7:0]             ctrl_q, ctrl_d, d_out_q, d_out_d;
    logic [2:0]             bsr_bit_q, bsr_bit_d;
    logic                   bsr_val_q, bsr_val_d, d_oe_q, d_oe_d, read_q, read_d;
    logic                   write_q, write_d, mode_set_q, mode_set_d, bsr_we_q, bsr_we_d;
    logic                   conflict_q, conflict_d;

    always_comb begin
        cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], CS_n};
        rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], RD_n};
        wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], WR_n};
    end

    assign cs     = ~cs_sync_q[SYNC_STAGES-1];
    assign rd     = ~rd_sync_q[SYNC_STAGES-1];
    assign wr     = ~wr_sync_q[SYNC_STAGES-1];
    // A write is committed only when WR is seen to end while CS is still held.
    assign commit = (state_q == WR_ACT) && cs && !rd && !wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cs && rd && wr)  state_d = ERR;
                else if (cs && wr)   state_d = WR_ACT;
                else if (cs && rd)   state_d = RD_ACT;
            end
            WR_ACT: begin
                if (!cs)             state_d = IDLE;
                else if (rd)         state_d = ERR;
                else if (!wr)        state_d = IDLE;
            end
            RD_ACT: begin
                if (!cs || !rd)      state_d = IDLE;
                else if (wr)         state_d = ERR;
            end
            ERR: begin
                if (!rd && !wr)      state_d = IDLE;
            end
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        ctrl_d     = ctrl_q;
        bsr_bit_d  = bsr_bit_q;
        bsr_val_d  = bsr_val_q;
        write_d    = 1'b0;
        mode_set_d = 1'b0;
        bsr_we_d   = 1'b0;
        conflict_d = 1'b0;
        read_d     = 1'b0;
        d_oe_d     = 1'b0;
        d_out_d    = 8'h00;
        if (state_d == WR_ACT) begin
            cap_addr_d = A;
            cap_data_d = D_in;
        end
        if (commit) begin
            if (cap_addr_q != ADDR_CTRL) begin
                write_d   = 1'b1;
                addr_d    = cap_addr_q;
                wr_data_d = cap_data_q;
            end else if (cap_data_q[7]) begin
                ctrl_d     = cap_data_q;
                mode_set_d = 1'b1;
            end else begin
                bsr_we_d  = 1'b1;
                bsr_bit_d = cap_data_q[3:1];
                bsr_val_d = cap_data_q[0];
            end
        end
        if (state_d == ERR && state_q != ERR) conflict_d = 1'b1;
        // rd_data follows addr_out, so D_out trails the address by one cycle.
        if (state_d == RD_ACT) begin
            addr_d = A;
            if (A != ADDR_CTRL) begin
                read_d  = 1'b1;
                d_oe_d  = 1'b1;
                d_out_d = rd_data;
            end else begin
`ifdef PPI_CTRL_READBACK_EN
                d_oe_d  = 1'b1;
                d_out_d = ctrl_q;
`else
                d_oe_d  = 1'b0;
                d_out_d = 8'h00;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q  <= '1;
            rd_sync_q  <= '1;
            wr_sync_q  <= '1;
            cap_addr_q <= 2'b00;
            cap_data_q <= 8'h00;
            addr_q     <= 2'b00;
            wr_data_q  <= 8'h00;
            ctrl_q     <= CTRL_RESET;
            bsr_bit_q  <= 3'd0;
            bsr_val_q  <= 1'b0;
            write_q    <= 1'b0;
            mode_set_q <= 1'b0;
            bsr_we_q   <= 1'b0;
            conflict_q <= 1'b0;
            read_q     <= 1'b0;
            d_oe_q     <= 1'b0;
            d_out_q    <= 8'h00;
        end else begin
            cs_sync_q  <= cs_sync_d;
            rd_sync_q  <= rd_sync_d;
            wr_sync_q  <= wr_sync_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            ctrl_q     <= ctrl_d;
            bsr_bit_q  <= bsr_bit_d;
            bsr_val_q  <= bsr_val_d;
            write_q    <= write_d;
            mode_set_q <= mode_set_d;
            bsr_we_q   <= bsr_we_d;
            conflict_q <= conflict_d;
            read_q     <= read_d;
            d_oe_q     <= d_oe_d;
            d_out_q    <= d_out_d;
        end
    end

    assign D_out        = d_out_q;
    assign D_oe         = d_oe_q;
    assign addr_out     = addr_q;
    assign READ         = read_q;
    assign WRITE        = write_q;
    assign wr_data      = wr_data_q;
    assign ctrl_word    = ctrl_q;
    assign mode_set     = mode_set_q;
    assign bsr_we       = bsr_we_q;
    assign bsr_bit      = bsr_bit_q;
    assign bsr_val      = bsr_val_q;
    assign bus_conflict = conflict_q;
endmodule

// File: tb/tb_ppi_bus_control.sv
// Self-checking bench for ppi_bus_control: scenario tasks with randomized bus cycles against a behavioural model.
module tb_ppi_bus_control;
    localparam int         SYNC     = 2;
    localparam logic [7:0] CTRL_RST = 8'h9B;

    logic       clk = 1'b0;
    logic       reset, CS_n, RD_n, WR_n, D_oe, READ, WRITE, mode_set, bsr_we, bsr_val, bus_conflict;
    logic [1:0] A, addr_out;
    logic [7:0] D_in, D_out, rd_data, wr_data, ctrl_word;
    logic [2:0] bsr_bit;
    logic [7:0] port_mem [4];
    logic [7:0] model_ctrl;
    int         total = 0;
    int         bad = 0;
    int         n_write, c_write, n_mode, c_mode, n_bsr, c_bsr, n_conf, c_conf;
    logic [1:0] o_addr;
    logic [7:0] o_data, o_ctrl;
    logic [2:0] o_bit;
    logic       o_val;

    assign rd_data = port_mem[addr_out];
    always #5 clk = ~clk;

    ppi_bus_control #(.SYNC_STAGES(SYNC), .CTRL_RESET(CTRL_RST)) dut (
        .clk(clk), .reset(reset), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A(A), .D_in(D_in),
        .D_out(D_out), .D_oe(D_oe), .rd_data(rd_data), .addr_out(addr_out), .READ(READ),
        .WRITE(WRITE), .wr_data(wr_data), .ctrl_word(ctrl_word), .mode_set(mode_set),
        .bsr_we(bsr_we), .bsr_bit(bsr_bit), .bsr_val(bsr_val), .bus_conflict(bus_conflict)
    );

    // Records how many cycles each pulse was high and when, over n cycles.
    task automatic watch(input int n);
        n_write = 0; c_write = 0; n_mode = 0; c_mode = 0; n_bsr = 0; c_bsr = 0; n_conf = 0; c_conf = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (WRITE === 1'b1) begin n_write++; c_write = i; o_addr = addr_out; o_data = wr_data; end
            if (mode_set === 1'b1) begin n_mode++; c_mode = i; o_ctrl = ctrl_word; end
            if (bsr_we === 1'b1) begin n_bsr++; c_bsr = i; o_bit = bsr_bit; o_val = bsr_val; end
            if (bus_conflict === 1'b1) begin n_conf++; c_conf = i; end
        end
    endtask

    task automatic wr_cycle(input logic [1:0] a, input logic [7:0] d, input int low, input int win);
        @(negedge clk); CS_n = 1'b0; A = a; D_in = d; WR_n = 1'b0;
        repeat (low) @(negedge clk);
        WR_n = 1'b1;
        watch(win);
    endtask

    task automatic cs_release();
        @(negedge clk); CS_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        CS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; A = 2'b00; D_in = 8'h00; reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++;
        if (ctrl_word !== CTRL_RST) begin bad++; $display("FAIL reset_ctrl: got %h want %h", ctrl_word, CTRL_RST); end
        total++;
        if ({READ, WRITE, mode_set, bsr_we, bus_conflict, D_oe} !== 6'b0) begin
            bad++; $display("FAIL reset_pulses: got %b want 000000", {READ, WRITE, mode_set, bsr_we, bus_conflict, D_oe});
        end
        total++;
        if ({addr_out, wr_data, bsr_bit, bsr_val, D_out} !== 22'h0) begin
            bad++; $display("FAIL reset_data: got %h want 0", {addr_out, wr_data, bsr_bit, bsr_val, D_out});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_ctrl = CTRL_RST;
        repeat (SYNC + 1) @(negedge clk);
    endtask

    task automatic test_mode_write();
        wr_cycle(2'b11, 8'h80, 3, SYNC + 3);
        model_ctrl = 8'h80;
        total++;
        if (!(n_mode == 1 && c_mode == SYNC + 1 && o_ctrl === 8'h80 && n_write == 0 && n_bsr == 0)) begin
            bad++;
            $display("FAIL mode_write: mode n=%0d cyc=%0d ctrl=%h write n=%0d bsr n=%0d, want mode n=1 cyc=%0d ctrl=80 write 0 bsr 0",
                     n_mode, c_mode, o_ctrl, n_write, n_bsr, SYNC + 1);
        end
        total++;
        if (ctrl_word !== 8'h80) begin bad++; $display("FAIL mode_ctrl: got %h want 80", ctrl_word); end
        cs_release();
    endtask

    task automatic test_back_to_back();
        logic [1:0] ea [2];
        logic [7:0] ed [2];
        ea[0] = 2'b00; ed[0] = 8'hFF; ea[1] = 2'b01; ed[1] = 8'h08;
        for (int k = 0; k < 2; k++) begin
            wr_cycle(ea[k], ed[k], 2, SYNC + 2);
            total++;
            if (!(n_write == 1 && c_write == SYNC + 1 && o_addr === ea[k] && o_data === ed[k] && n_mode == 0 && n_bsr == 0)) begin
                bad++;
                $display("FAIL b2b_write%0d: n=%0d cyc=%0d addr=%0d data=%h mode=%0d bsr=%0d, want n=1 cyc=%0d addr=%0d data=%h",
                         k, n_write, c_write, o_addr, o_data, n_mode, n_bsr, SYNC + 1, ea[k], ed[k]);
            end
        end
        total++;
        if (ctrl_word !== model_ctrl) begin bad++; $display("FAIL b2b_ctrl: got %h want %h", ctrl_word, model_ctrl); end
        cs_release();
    endtask

    task automatic test_bsr();
        logic [7:0] cmd [2];
        cmd[0] = 8'h0B; cmd[1] = 8'h0A;
        for (int k = 0; k < 2; k++) begin
            wr_cycle(2'b11, cmd[k], 2, SYNC + 3);
            total++;
            if (!(n_bsr == 1 && c_bsr == SYNC + 1 && o_bit === 3'd5 && o_val === ((k == 0) ? 1'b1 : 1'b0) && n_mode == 0 && n_write == 0)) begin
                bad++;
                $display("FAIL bsr%0d: n=%0d cyc=%0d bit=%0d val=%b mode=%0d write=%0d, want n=1 cyc=%0d bit=5 val=%0d",
                         k, n_bsr, c_bsr, o_bit, o_val, n_mode, n_write, SYNC + 1, (k == 0) ? 1 : 0);
            end
            total++;
            if (ctrl_word !== model_ctrl) begin bad++; $display("FAIL bsr_ctrl%0d: got %h want %h", k, ctrl_word, model_ctrl); end
            cs_release();
        end
    endtask

    task automatic test_read();
        logic [1:0] addrs [4];
        logic [1:0] a;
        logic [7:0] exp_dout;
        logic       exp_oe, exp_read;
        int         oe_on, rd_on, off;
        for (int k = 0; k < 4; k++) port_mem[k] = 8'($urandom);
        port_mem[2] = 8'h3C;
        addrs[0] = 2'b10; addrs[1] = 2'($urandom_range(0, 1)); addrs[2] = 2'b11; addrs[3] = 2'($urandom_range(0, 2));
        for (int k = 0; k < 4; k++) begin
            a = addrs[k];
            exp_read = (a != 2'b11);
`ifdef PPI_CTRL_READBACK_EN
            exp_oe = 1'b1;
`else
            exp_oe = exp_read;
`endif
            exp_dout = (a == 2'b11) ? model_ctrl : port_mem[a];
            @(negedge clk); CS_n = 1'b0; A = a; RD_n = 1'b0;
            oe_on = 0; rd_on = 0;
            for (int i = 1; i <= SYNC + 4; i++) begin
                @(posedge clk); #1;
                if (D_oe === 1'b1 && oe_on == 0) oe_on = i;
                if (READ === 1'b1 && rd_on == 0) rd_on = i;
            end
            total++;
            if (oe_on != (exp_oe ? SYNC + 1 : 0)) begin
                bad++; $display("FAIL read_oe a=%0d: first D_oe cycle %0d want %0d", a, oe_on, exp_oe ? SYNC + 1 : 0);
            end
            total++;
            if (rd_on != (exp_read ? SYNC + 1 : 0)) begin
                bad++; $display("FAIL read_level a=%0d: first READ cycle %0d want %0d", a, rd_on, exp_read ? SYNC + 1 : 0);
            end
            if (exp_oe) begin
                total++;
                if (D_out !== exp_dout) begin bad++; $display("FAIL read_data a=%0d: got %h want %h", a, D_out, exp_dout); end
            end
            @(negedge clk); RD_n = 1'b1;
            off = 0;
            for (int i = 1; i <= SYNC + 3; i++) begin
                @(posedge clk); #1;
                if (D_oe === 1'b0 && READ === 1'b0 && off == 0) off = i;
            end
            total++;
            if (off != (exp_oe ? SYNC + 1 : 1)) begin
                bad++; $display("FAIL read_release a=%0d: idle at cycle %0d want %0d", a, off, exp_oe ? SYNC + 1 : 1);
            end
            cs_release();
        end
    endtask

    task automatic test_abort();
        logic [1:0] aa [2];
        logic [7:0] dd [2];
        aa[0] = 2'b11; dd[0] = 8'h01; aa[1] = 2'($urandom_range(0, 2)); dd[1] = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); CS_n = 1'b0; A = aa[k]; D_in = dd[k]; WR_n = 1'b0;
            repeat (3) @(negedge clk);
            CS_n = 1'b1;
            @(negedge clk); WR_n = 1'b1;
            watch(SYNC + 4);
            total++;
            if (n_write + n_mode + n_bsr + n_conf != 0) begin
                bad++; $display("FAIL abort%0d: pulses write=%0d mode=%0d bsr=%0d conf=%0d want all 0", k, n_write, n_mode, n_bsr, n_conf);
            end
            total++;
            if (ctrl_word !== model_ctrl) begin bad++; $display("FAIL abort_ctrl%0d: got %h want %h", k, ctrl_word, model_ctrl); end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_conflict();
        // Both strobes together from idle.
        @(negedge clk); CS_n = 1'b0; A = 2'b00; D_in = 8'h55; WR_n = 1'b0; RD_n = 1'b0;
        watch(SYNC + 3);
        total++;
        if (!(n_conf == 1 && c_conf == SYNC + 1)) begin
            bad++; $display("FAIL conflict_sim: n=%0d cyc=%0d want n=1 cyc=%0d", n_conf, c_conf, SYNC + 1);
        end
        @(negedge clk); WR_n = 1'b1; RD_n = 1'b1;
        watch(SYNC + 4);
        total++;
        if (n_write + n_mode + n_bsr + n_conf != 0) begin
            bad++; $display("FAIL conflict_sim_commit: write=%0d mode=%0d bsr=%0d conf=%0d want all 0", n_write, n_mode, n_bsr, n_conf);
        end
        cs_release();
        // RD joins a write already in progress.
        @(negedge clk); CS_n = 1'b0; A = 2'b11; D_in = 8'h83; WR_n = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        RD_n = 1'b0;
        watch(SYNC + 3);
        total++;
        if (!(n_conf == 1 && c_conf == SYNC + 1)) begin
            bad++; $display("FAIL conflict_late: n=%0d cyc=%0d want n=1 cyc=%0d", n_conf, c_conf, SYNC + 1);
        end
        @(negedge clk); WR_n = 1'b1;
        watch(SYNC + 3);
        @(negedge clk); RD_n = 1'b1;
        watch(SYNC + 3);
        total++;
        if (n_write + n_mode + n_bsr + n_conf != 0 || ctrl_word !== model_ctrl) begin
            bad++; $display("FAIL conflict_late_commit: write=%0d mode=%0d bsr=%0d ctrl=%h want no pulses ctrl=%h",
                            n_write, n_mode, n_bsr, ctrl_word, model_ctrl);
        end
        cs_release();
    endtask

    task automatic test_random_writes();
        logic [1:0] a;
        logic [7:0] d;
        int         low;
        for (int k = 0; k < 12; k++) begin
            a = 2'($urandom);
            d = 8'($urandom);
            low = int'($urandom_range(1, 4));
            wr_cycle(a, d, low, SYNC + 3);
            total++;
            if (a != 2'b11) begin
                if (!(n_write == 1 && c_write == SYNC + 1 && o_addr === a && o_data === d && n_mode == 0 && n_bsr == 0)) begin
                    bad++; $display("FAIL rnd_port[%0d] a=%0d d=%h: n=%0d cyc=%0d addr=%0d data=%h mode=%0d bsr=%0d",
                                    k, a, d, n_write, c_write, o_addr, o_data, n_mode, n_bsr);
                end
            end else if (d[7]) begin
                model_ctrl = d;
                if (!(n_mode == 1 && c_mode == SYNC + 1 && o_ctrl === d && n_write == 0 && n_bsr == 0)) begin
                    bad++; $display("FAIL rnd_mode[%0d] d=%h: n=%0d cyc=%0d ctrl=%h write=%0d bsr=%0d",
                                    k, d, n_mode, c_mode, o_ctrl, n_write, n_bsr);
                end
            end else begin
                if (!(n_bsr == 1 && c_bsr == SYNC + 1 && o_bit === d[3:1] && o_val === d[0] && n_write == 0 && n_mode == 0)) begin
                    bad++; $display("FAIL rnd_bsr[%0d] d=%h: n=%0d cyc=%0d bit=%0d val=%b want bit=%0d val=%b",
                                    k, d, n_bsr, c_bsr, o_bit, o_val, d[3:1], d[0]);
                end
            end
            total++;
            if (ctrl_word !== model_ctrl) begin bad++; $display("FAIL rnd_ctrl[%0d]: got %h want %h", k, ctrl_word, model_ctrl); end
            cs_release();
        end
    endtask

    task automatic test_reset_mid_access();
        wr_cycle(2'b11, 8'h88, 2, SYNC + 3);
        model_ctrl = 8'h88;
        total++;
        if (ctrl_word !== 8'h88) begin bad++; $display("FAIL pre_reset_ctrl: got %h want 88", ctrl_word); end
        cs_release();
        @(negedge clk); CS_n = 1'b0; A = 2'b11; D_in = 8'hC5; WR_n = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (ctrl_word !== CTRL_RST || {WRITE, mode_set, bsr_we, bus_conflict, D_oe} !== 5'b0) begin
            bad++; $display("FAIL midreset_async: ctrl=%h pulses=%b want ctrl=%h pulses=00000",
                            ctrl_word, {WRITE, mode_set, bsr_we, bus_conflict, D_oe}, CTRL_RST);
        end
        model_ctrl = CTRL_RST;
        @(negedge clk); reset = 1'b0; WR_n = 1'b1;
        watch(SYNC + 4);
        total++;
        if (n_write + n_mode + n_bsr + n_conf != 0 || ctrl_word !== CTRL_RST) begin
            bad++; $display("FAIL midreset_drop: write=%0d mode=%0d bsr=%0d conf=%0d ctrl=%h want none ctrl=%h",
                            n_write, n_mode, n_bsr, n_conf, ctrl_word, CTRL_RST);
        end
        cs_release();
    endtask

    initial begin
        test_reset();
        test_mode_write();
        test_back_to_back();
        test_bsr();
        test_read();
        test_abort();
        test_conflict();
        test_random_writes();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
